vram_slot_arbiter: RTL and testbench

VRAM_SLOT_ARBITER -- requirements
Module: vram_slot_arbiter

---
 rtl/vram_arb_pkg.sv | 17 +
 rtl/arb_wait_ctr.sv | 32 +++
 rtl/vram_slot_arbiter.sv | 148 ++++++++++++++
 tb/tb_vram_slot_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_arb_pkg.sv
// Shared types and default sizing for the VRAM slot arbiter.
package vram_arb_pkg;

  localparam int DEF_AW       = 13;
  localparam int DEF_DW       = 16;
  localparam int DEF_MAX_WAIT = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    VID_ACC  = 3'd1,
    VID_DATA = 3'd2,
    CPU_ACC  = 3'd3,
    CPU_DATA = 3'd4,
    CPU_HOLD = 3'd5
  } arb_state_e;

endpackage

// File: rtl/arb_wait_ctr.sv
// Saturating 8-bit CPU wait counter; sat_o flags that the CPU has waited
// MAX_WAIT cycles and must win the next arbitration.
module arb_wait_ctr #(
  parameter int MAX_WAIT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic inc_i,
  input  logic clr_i,
  output logic sat_o
);

  localparam logic [7:0] SAT = 8'(MAX_WAIT);

  logic [7:0] cnt_q, cnt_d;

  // Clear wins over increment; stop counting at the threshold
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                    cnt_d = '0;
    else if (inc_i && cnt_q < SAT) cnt_d = cnt_q + 8'd1;
  end

  // Counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign sat_o = (cnt_q >= SAT);

endmodule

// File: rtl/vram_slot_arbiter.sv
// Single-port VRAM arbiter between a video fetcher and a CPU.
// Video wins in active display, CPU wins in blanking. One access in flight.
// Optional: define VRAM_ARB_STARVE_EN to let a CPU that has waited MAX_WAIT
// cycles win even in active display.
module vram_slot_arbiter
  import vram_arb_pkg::*;
#(
  parameter int AW       = DEF_AW,
  parameter int DW       = DEF_DW,
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          hbl,
  input  logic          vbl,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic          vid_ack,
  output logic [DW-1:0] vid_data,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_din,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_dout,
  output logic          ram_cs,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  arb_state_e    state_q, state_d;
  logic          ram_cs_q, ram_cs_d;
  logic          ram_we_q, ram_we_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [DW-1:0] ram_din_q, ram_din_d;
  logic          vid_ack_q, vid_ack_d;
  logic [DW-1:0] vid_data_q, vid_data_d;
  logic          cpu_ack_q, cpu_ack_d;
  logic [DW-1:0] cpu_dout_q, cpu_dout_d;
  logic          we_q, we_d;      // remembers whether the CPU access is a write
  logic          cpu_grant;
  logic          starved;

`ifdef VRAM_ARB_STARVE_EN
  logic cpu_busy;
  assign cpu_busy = (state_q == CPU_ACC) || (state_q == CPU_DATA) || (state_q == CPU_HOLD);

  arb_wait_ctr #(.MAX_WAIT(MAX_WAIT)) u_wait_ctr (
    .clk   (clk),
    .reset (reset),
    .inc_i (cpu_req && !cpu_grant && !cpu_busy),
    .clr_i (!cpu_req || cpu_grant || cpu_busy),
    .sat_o (starved)
  );
`else
  assign starved = 1'b0;
`endif

  // Next-state and registered-output decode; arbitration only in IDLE
  always_comb begin
    state_d    = state_q;
    ram_cs_d   = 1'b0;
    ram_we_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    vid_ack_d  = 1'b0;
    vid_data_d = vid_data_q;
    cpu_ack_d  = cpu_ack_q;
    cpu_dout_d = cpu_dout_q;
    we_d       = we_q;
    cpu_grant  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cpu_req && (hbl || vbl || !vid_req || starved)) begin
          cpu_grant  = 1'b1;
          state_d    = CPU_ACC;
          ram_cs_d   = 1'b1;
          ram_we_d   = cpu_we;
          ram_addr_d = cpu_addr;
          ram_din_d  = cpu_din;
          we_d       = cpu_we;
        end else if (vid_req) begin
          state_d    = VID_ACC;
          ram_cs_d   = 1'b1;
          ram_addr_d = vid_addr;
        end
      end
      VID_ACC:  state_d = VID_DATA;
      VID_DATA: begin
        vid_data_d = ram_dout;
        vid_ack_d  = 1'b1;
        state_d    = IDLE;
      end
      CPU_ACC:  state_d = CPU_DATA;
      CPU_DATA: begin
        if (!we_q) cpu_dout_d = ram_dout;
        cpu_ack_d = 1'b1;
        state_d   = CPU_HOLD;
      end
      CPU_HOLD: begin
        if (!cpu_req) begin
          cpu_ack_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default:  state_d = IDLE;
    endcase
  end

  // State and output registers; reset discards any access in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      ram_cs_q   <= 1'b0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      vid_ack_q  <= 1'b0;
      vid_data_q <= '0;
      cpu_ack_q  <= 1'b0;
      cpu_dout_q <= '0;
      we_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      ram_cs_q   <= ram_cs_d;
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      vid_ack_q  <= vid_ack_d;
      vid_data_q <= vid_data_d;
      cpu_ack_q  <= cpu_ack_d;
      cpu_dout_q <= cpu_dout_d;
      we_q       <= we_d;
    end
  end

  assign ram_cs   = ram_cs_q;
  assign ram_we   = ram_we_q;
  assign ram_addr = ram_addr_q;
  assign ram_din  = ram_din_q;
  assign vid_ack  = vid_ack_q;
  assign vid_data = vid_data_q;
  assign cpu_ack  = cpu_ack_q;
  assign cpu_dout = cpu_dout_q;

endmodule

// File: tb/tb_vram_slot_arbiter.sv
// Scoreboard bench for vram_slot_arbiter with a behavioural 1-cycle RAM.
module tb_vram_slot_arbiter;
  localparam int AW = 13;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset, hbl, vbl;
  logic          vid_req, vid_ack, cpu_req, cpu_we, cpu_ack, ram_cs, ram_we;
  logic [AW-1:0] vid_addr, cpu_addr, ram_addr;
  logic [DW-1:0] vid_data, cpu_din, cpu_dout, ram_din, ram_dout;

  int nvec = 0;
  int nerr = 0;

  logic [DW-1:0] mem     [0:8191];
  logic [DW-1:0] ref_mem [0:8191];
  logic [DW-1:0] vid_exp_q[$];
  logic [DW-1:0] cpu_exp_q[$];
  logic [DW-1:0] exp_dout;

  always #5 clk = ~clk;

  vram_slot_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(8)) dut (
    .clk(clk), .reset(reset), .hbl(hbl), .vbl(vbl),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_data(vid_data),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_ack(cpu_ack), .cpu_dout(cpu_dout),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  // Synchronous single-port RAM
  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      ram_dout <= mem[ram_addr];
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    mem[a] = d;
    ref_mem[a] = d;
  endtask

  task automatic cpu_txn(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         output logic [DW-1:0] dout, output int cs_n, output bit to);
    cpu_we = we; cpu_addr = a; cpu_din = d; cpu_req = 1'b1;
    cs_n = 0; to = 1'b1; dout = 'x;
    for (int i = 0; i < 20; i++) begin
      step();
      if (ram_cs) cs_n++;
      if (cpu_ack) begin to = 1'b0; break; end
    end
    dout = cpu_dout;
    cpu_req = 1'b0;
    if (!to) begin
      to = 1'b1;
      for (int i = 0; i < 5; i++) begin
        step();
        if (!cpu_ack) begin to = 1'b0; break; end
      end
    end
  endtask

  task automatic vid_txn(input logic [AW-1:0] a, output logic [DW-1:0] data,
                         output int cs_n, output bit to);
    vid_addr = a; vid_req = 1'b1; cs_n = 0; to = 1'b1; data = 'x;
    for (int i = 0; i < 20; i++) begin
      step();
      if (ram_cs) cs_n++;
      if (vid_ack) begin to = 1'b0; data = vid_data; break; end
    end
    vid_req = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; hbl = 0; vbl = 0; vid_req = 0; cpu_req = 0; cpu_we = 0;
    vid_addr = '0; cpu_addr = '0; cpu_din = '0;
    step();
    nvec++; if ({ram_cs, ram_we, vid_ack, cpu_ack} !== 4'b0) begin nerr++;
      $display("FAIL reset_ctl got %b want 0000", {ram_cs, ram_we, vid_ack, cpu_ack}); end
    nvec++; if (ram_addr !== '0 || ram_din !== '0) begin nerr++;
      $display("FAIL reset_ram got addr=%h din=%h want 0", ram_addr, ram_din); end
    nvec++; if (vid_data !== '0 || cpu_dout !== '0) begin nerr++;
      $display("FAIL reset_data got vid=%h cpu=%h want 0", vid_data, cpu_dout); end
    step();
    reset = 1'b0;
    exp_dout = '0;
    step();
  endtask

  task automatic test_vid_priority();
    logic [DW-1:0] e;
    hbl = 0; vbl = 0;
    vid_addr = 13'h0040; vid_req = 1;
    cpu_addr = 13'h0123; cpu_we = 0; cpu_req = 1;
    vid_exp_q.push_back(ref_mem[13'h0040]);
    cpu_exp_q.push_back(ref_mem[13'h0123]);
    step();
    nvec++; if ({ram_cs, ram_we, ram_addr} !== {1'b1, 1'b0, 13'h0040}) begin nerr++;
      $display("FAIL vid_first got cs=%b we=%b addr=%h want 1 0 0040", ram_cs, ram_we, ram_addr); end
    step();
    nvec++; if (ram_cs !== 1'b0 || vid_ack !== 1'b0) begin nerr++;
      $display("FAIL vid_cs_1cyc got cs=%b ack=%b want 0 0", ram_cs, vid_ack); end
    step();
    e = vid_exp_q.pop_front();
    nvec++; if (vid_ack !== 1'b1 || vid_data !== e) begin nerr++;
      $display("FAIL vid_ack_lat got ack=%b data=%h want 1 %h", vid_ack, vid_data, e); end
    vid_req = 0;
    step();
    nvec++; if ({ram_cs, ram_we, ram_addr} !== {1'b1, 1'b0, 13'h0123} || vid_ack !== 1'b0) begin nerr++;
      $display("FAIL cpu_after_vid got cs=%b we=%b addr=%h vack=%b want 1 0 0123 0",
               ram_cs, ram_we, ram_addr, vid_ack); end
    step(); step();
    e = cpu_exp_q.pop_front();
    nvec++; if (cpu_ack !== 1'b1 || cpu_dout !== e) begin nerr++;
      $display("FAIL cpu_rd got ack=%b dout=%h want 1 %h", cpu_ack, cpu_dout, e); end
    exp_dout = e;
    cpu_req = 0;
    step();
    nvec++; if (cpu_ack !== 1'b0) begin nerr++;
      $display("FAIL cpu_ack_drop got %b want 0", cpu_ack); end
  endtask

  task automatic test_blank_cpu();
    logic [DW-1:0] e, d;
    int cs_n, got;
    bit to;
    hbl = 1; vbl = 0;
    vid_addr = 13'h0040; vid_req = 1;
    cpu_addr = 13'h0100; cpu_we = 1; cpu_din = 16'h1234; cpu_req = 1;
    ref_mem[13'h0100] = 16'h1234;
    cpu_exp_q.push_back(exp_dout);
    vid_exp_q.push_back(ref_mem[13'h0040]);
    step();
    nvec++; if ({ram_cs, ram_we, ram_addr, ram_din} !== {1'b1, 1'b1, 13'h0100, 16'h1234}) begin nerr++;
      $display("FAIL blank_cpu_first got cs=%b we=%b addr=%h din=%h want 1 1 0100 1234",
               ram_cs, ram_we, ram_addr, ram_din); end
    step(); step();
    e = cpu_exp_q.pop_front();
    nvec++; if (cpu_ack !== 1'b1 || cpu_dout !== e) begin nerr++;
      $display("FAIL wr_ack got ack=%b dout=%h want 1 %h", cpu_ack, cpu_dout, e); end
    for (int i = 0; i < 3; i++) begin
      step();
      nvec++; if (cpu_ack !== 1'b1 || vid_ack !== 1'b0 || ram_cs !== 1'b0) begin nerr++;
        $display("FAIL hold_%0d got cack=%b vack=%b cs=%b want 1 0 0", i, cpu_ack, vid_ack, ram_cs); end
    end
    cpu_req = 0;
    step();
    nvec++; if (cpu_ack !== 1'b0) begin nerr++;
      $display("FAIL hold_release got %b want 0", cpu_ack); end
    got = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (vid_ack) begin got = 1; break; end
    end
    e = vid_exp_q.pop_front();
    nvec++; if (got != 1 || vid_data !== e) begin nerr++;
      $display("FAIL vid_after_cpu got ack_seen=%0d data=%h want 1 %h", got, vid_data, e); end
    vid_req = 0; hbl = 0;
    step();
    cpu_exp_q.push_back(ref_mem[13'h0100]);
    cpu_txn(1'b0, 13'h0100, 16'h0, d, cs_n, to);
    e = cpu_exp_q.pop_front();
    exp_dout = e;
    nvec++; if (to || d !== e) begin nerr++;
      $display("FAIL readback got to=%0b dout=%h want 0 %h", to, d, e); end
  endtask

  task automatic test_starve();
    int grant_at, got;
    logic [DW-1:0] e;
    hbl = 0; vbl = 0;
    vid_addr = 13'h0040; vid_req = 1;
    cpu_addr = 13'h0200; cpu_we = 0; cpu_req = 1;
    cpu_exp_q.push_back(ref_mem[13'h0200]);
    grant_at = -1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (ram_cs && ram_addr == 13'h0200) begin grant_at = i; break; end
    end
`ifdef VRAM_ARB_STARVE_EN
    nvec++; if (grant_at != 9) begin nerr++;
      $display("FAIL starve_grant got cycle %0d want 9", grant_at); end
`else
    nvec++; if (grant_at != -1) begin nerr++;
      $display("FAIL strict_vid got cpu grant at cycle %0d want none", grant_at); end
`endif
    vid_req = 0;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      if (cpu_ack) begin got = 1; break; end
      step();
    end
    e = cpu_exp_q.pop_front();
    exp_dout = e;
    nvec++; if (got != 1 || cpu_dout !== e) begin nerr++;
      $display("FAIL starve_rd got ack_seen=%0d dout=%h want 1 %h", got, cpu_dout, e); end
    cpu_req = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (!cpu_ack) break;
    end
    step(); step();
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] e;
    hbl = 1;
    cpu_addr = 13'h0300; cpu_we = 0; cpu_req = 1;
    step();
    nvec++; if (ram_cs !== 1'b1) begin nerr++;
      $display("FAIL rst_pre_cs got %b want 1", ram_cs); end
    #1 reset = 1;
    #1;
    nvec++; if ({ram_cs, ram_we, vid_ack, cpu_ack} !== 4'b0 || ram_addr !== '0 || ram_din !== '0
                || vid_data !== '0 || cpu_dout !== '0) begin nerr++;
      $display("FAIL rst_mid got cs=%b we=%b addr=%h din=%h cack=%b dout=%h want all 0",
               ram_cs, ram_we, ram_addr, ram_din, cpu_ack, cpu_dout); end
    exp_dout = '0;
    step(); step();
    reset = 0;
    cpu_exp_q.push_back(ref_mem[13'h0300]);
    step();
    nvec++; if (ram_cs !== 1'b1 || cpu_ack !== 1'b0) begin nerr++;
      $display("FAIL rst_regrant got cs=%b ack=%b want 1 0", ram_cs, cpu_ack); end
    step();
    nvec++; if (cpu_ack !== 1'b0) begin nerr++;
      $display("FAIL rst_no_early_ack got %b want 0", cpu_ack); end
    step();
    e = cpu_exp_q.pop_front();
    exp_dout = e;
    nvec++; if (cpu_ack !== 1'b1 || cpu_dout !== e) begin nerr++;
      $display("FAIL rst_fresh_rd got ack=%b dout=%h want 1 %h", cpu_ack, cpu_dout, e); end
    cpu_req = 0; hbl = 0;
    step(); step();
  endtask

  task automatic test_random();
    logic [DW-1:0] e, d, wd;
    logic [AW-1:0] a;
    int cs_n, kind;
    bit to;
    preload(13'h1FFF, 16'hA5C3);
    cpu_exp_q.push_back(ref_mem[13'h1FFF]);
    cpu_txn(1'b0, 13'h1FFF, 16'h0, d, cs_n, to);
    e = cpu_exp_q.pop_front();
    exp_dout = e;
    nvec++; if (to || cs_n != 1 || d !== e) begin nerr++;
      $display("FAIL top_addr got to=%0b cs=%0d dout=%h want 0 1 %h", to, cs_n, d, e); end
    for (int n = 0; n < 100; n++) begin
      kind = $urandom_range(0, 2);
      a    = AW'($urandom);
      wd   = DW'($urandom);
      hbl  = 1'($urandom);
      vbl  = 1'($urandom);
      if (kind == 0) begin
        vid_exp_q.push_back(ref_mem[a]);
        vid_txn(a, d, cs_n, to);
        e = vid_exp_q.pop_front();
      end else if (kind == 1) begin
        cpu_exp_q.push_back(ref_mem[a]);
        exp_dout = ref_mem[a];
        cpu_txn(1'b0, a, wd, d, cs_n, to);
        e = cpu_exp_q.pop_front();
      end else begin
        ref_mem[a] = wd;
        cpu_exp_q.push_back(exp_dout);
        cpu_txn(1'b1, a, wd, d, cs_n, to);
        e = cpu_exp_q.pop_front();
      end
      nvec++; if (to || d !== e) begin nerr++;
        $display("FAIL rnd_%0d kind=%0d addr=%h got to=%0b data=%h want %h", n, kind, a, to, d, e); end
      nvec++; if (cs_n != 1) begin nerr++;
        $display("FAIL rnd_cs_%0d got %0d cs cycles want 1", n, cs_n); end
    end
    hbl = 0; vbl = 0;
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) begin
      mem[i]     = DW'(i * 7) ^ 16'h5A5A;
      ref_mem[i] = DW'(i * 7) ^ 16'h5A5A;
    end
    preload(13'h0040, 16'hBEEF);
    test_reset();
    test_vid_priority();
    test_blank_cpu();
    test_starve();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
